// File: rtl/spislave_swc_if.sv
// spislave_swc_if: SPI lines, mode config, tx/rx word handshake and status of the SPI slave endpoint.
interface spislave_swc_if;
  logic cpol, cpha, dff, lsbfirst;
  logic sck, mosi, miso;
  logic [15:0] tx_data;
  logic tx_valid, tx_ready;
  logic [15:0] rx_data;
  logic rx_valid, rx_ready;
  logic busy, overrun, frame_err;
  modport master (
    output cpol, cpha, dff, lsbfirst, sck, mosi, tx_data, tx_valid, rx_ready,
    input miso, tx_ready, rx_data, rx_valid, busy, overrun, frame_err
  );
  modport slave (
    input cpol, cpha, dff, lsbfirst, sck, mosi, tx_data, tx_valid, rx_ready,
    output miso, tx_ready, rx_data, rx_valid, busy, overrun, frame_err
  );
endinterface

// File: rtl/spislave_swc.sv
// spislave_swc: oversampling SPI slave, 8/16-bit frames, valid/ready word ports.
// Define SPISLV_ECHO_EN to transmit the last received word when no tx word is offered.
module spislave_swc #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT = 256,
  parameter logic [15:0] TX_IDLE_WORD = 16'h0000
) (
  input logic pclk,
  input logic prst,
  spislave_swc_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state;
  logic [SYNC_STAGES-1:0] sck_sync, mosi_sync;
  logic sck_s, mosi_s, sck_d, loaded;
  logic rise, fall, sample_edge, shift_edge, lead;
  logic [4:0] bit_cnt, n_bits;
  logic [TW-1:0] idle_cnt;
  logic [15:0] rx_sh, tx_sh, tx_nxt, rx_in, rx_word, load_word;
  assign sck_s = sck_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign rise = sck_s & ~sck_d;
  assign fall = ~sck_s & sck_d;
  assign sample_edge = (bus.cpol ^ bus.cpha) ? fall : rise;
  assign shift_edge = (bus.cpol ^ bus.cpha) ? rise : fall;
  // only an edge leaving the idle level may open a frame; the trailing edge of a cpha=0 frame lands in IDLE
  assign lead = (rise | fall) && (sck_s != bus.cpol);
  assign n_bits = bus.dff ? 5'd16 : 5'd8;
  assign tx_nxt = bus.lsbfirst ? {1'b0, tx_sh[15:1]} : {tx_sh[14:0], 1'b0};
  assign rx_in = bus.lsbfirst ? {mosi_s, rx_sh[15:1]} : {rx_sh[14:0], mosi_s};
  assign rx_word = bus.dff ? rx_sh : {8'h00, bus.lsbfirst ? rx_sh[15:8] : rx_sh[7:0]};
`ifdef SPISLV_ECHO_EN
  assign load_word = bus.tx_valid ? bus.tx_data : bus.rx_data;
`else
  assign load_word = bus.tx_valid ? bus.tx_data : TX_IDLE_WORD;
`endif
  always_ff @(posedge pclk) begin
    if (prst) begin
      state <= IDLE;
      sck_sync <= {SYNC_STAGES{bus.cpol}};
      mosi_sync <= '0;
      sck_d <= bus.cpol;
      loaded <= 1'b0;
      bit_cnt <= '0;
      idle_cnt <= '0;
      rx_sh <= '0;
      tx_sh <= '0;
      bus.miso <= 1'b0;
      bus.tx_ready <= 1'b0;
      bus.rx_data <= '0;
      bus.rx_valid <= 1'b0;
      bus.busy <= 1'b0;
      bus.overrun <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      sck_d <= sck_s;
      bus.tx_ready <= 1'b0;
      bus.frame_err <= 1'b0;
      if (bus.rx_valid && bus.rx_ready) bus.rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!loaded) begin
            loaded <= 1'b1;
            tx_sh <= (bus.lsbfirst || bus.dff) ? load_word : {load_word[7:0], 8'h00};
            bus.miso <= bus.lsbfirst ? load_word[0] : bus.dff ? load_word[15] : load_word[7];
            bus.tx_ready <= bus.tx_valid;
            rx_sh <= '0;
            bit_cnt <= '0;
            idle_cnt <= '0;
          end else if (lead) begin
            state <= ACTIVE;
            bus.busy <= 1'b1;
            if (sample_edge) begin
              rx_sh <= rx_in;
              bit_cnt <= 5'd1;
            end
          end
        end
        ACTIVE: begin
          idle_cnt <= (sck_s == bus.cpol) ? idle_cnt + 1'b1 : '0;
          if (sample_edge) begin
            rx_sh <= rx_in;
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt + 5'd1 == n_bits) state <= DONE;
          end
          if (shift_edge) begin
            tx_sh <= tx_nxt;
            bus.miso <= bus.lsbfirst ? tx_nxt[0] : tx_nxt[15];
          end
          if (sck_s == bus.cpol && idle_cnt == TW'(TIMEOUT - 1)) begin
            state <= IDLE;
            bus.busy <= 1'b0;
            loaded <= 1'b0;
            bus.frame_err <= 1'b1;
          end
        end
        DONE: begin
          if (bus.rx_valid && !bus.rx_ready) bus.overrun <= 1'b1;
          else begin
            bus.rx_data <= rx_word;
            bus.rx_valid <= 1'b1;
          end
          state <= IDLE;
          bus.busy <= 1'b0;
          loaded <= 1'b0;
          bit_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spislave_swc.sv
// tb_spislave_swc: directed frames acting as the SPI controller and as the local word consumer.
module tb_spislave_swc;
  localparam int H = 6;
  logic pclk = 1'b0;
  logic prst = 1'b1;
  int errors = 0, checks = 0, tx_cnt = 0, fe_cnt = 0;
  spislave_swc_if bus();
  spislave_swc dut (.pclk(pclk), .prst(prst), .bus(bus));
  always #5 pclk = ~pclk;

  task automatic tick;
    @(posedge pclk);
    #1;
    if (bus.tx_ready) tx_cnt++;
    if (bus.frame_err) fe_cnt++;
  endtask

  task automatic set_mode(input logic p, input logic h, input logic d, input logic l);
    bus.cpol = p; bus.cpha = h; bus.dff = d; bus.lsbfirst = l;
    bus.sck = p; bus.mosi = 1'b0;
  endtask

  task automatic do_reset;
    prst = 1'b1;
    tick; tick;
    prst = 1'b0;
    tx_cnt = 0; fe_cnt = 0;
  endtask

  task automatic spi_frame(input logic [15:0] w, input bit rd_done, output logic [15:0] got, output logic busy_mid);
    int n;
    logic b;
    n = bus.dff ? 16 : 8;
    got = '0; busy_mid = 1'b0;
    for (int i = 0; i < n; i++) begin
      b = bus.lsbfirst ? w[i] : w[n-1-i];
      if (!bus.cpha) begin
        bus.mosi = b; repeat (H) tick; bus.sck = ~bus.cpol;
      end else begin
        bus.sck = ~bus.cpol; bus.mosi = b; repeat (H) tick; bus.sck = bus.cpol;
      end
      if (bus.lsbfirst) got[i] = bus.miso; else got[n-1-i] = bus.miso;
      if (i == n - 1) busy_mid = bus.busy;
      if (i == n - 1 && rd_done) begin
        repeat (3) tick; bus.rx_ready = 1'b1; tick; bus.rx_ready = 1'b0; repeat (H - 4) tick;
      end else repeat (H) tick;
      if (!bus.cpha) bus.sck = bus.cpol;
    end
    bus.mosi = 1'b0;
    repeat (2 * H) tick;
  endtask

  task automatic test_reset;
    set_mode(0, 0, 0, 0);
    bus.tx_data = '0; bus.tx_valid = 1'b0; bus.rx_ready = 1'b0;
    prst = 1'b1; tick; tick;
    checks++; if (bus.miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b want 0", bus.miso); end
    checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL reset_tx_ready got %b want 0", bus.tx_ready); end
    checks++; if (bus.rx_data !== 16'h0) begin errors++; $display("FAIL reset_rx_data got %h want 0000", bus.rx_data); end
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", bus.rx_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", bus.overrun); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", bus.frame_err); end
    prst = 1'b0;
  endtask

  task automatic test_mode0;
    logic [15:0] got; logic bm;
    set_mode(0, 0, 0, 0);
    bus.tx_data = 16'h003C; bus.tx_valid = 1'b1;
    do_reset; tick; tick; bus.tx_valid = 1'b0;
    spi_frame(16'h00A5, 0, got, bm);
    checks++; if (bus.rx_data !== 16'h00A5) begin errors++; $display("FAIL m0_rx_data got %h want 00a5", bus.rx_data); end
    checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL m0_rx_valid got %b want 1", bus.rx_valid); end
    checks++; if (got[7:0] !== 8'h3C) begin errors++; $display("FAIL m0_miso got %h want 3c", got[7:0]); end
    checks++; if (tx_cnt !== 1) begin errors++; $display("FAIL m0_tx_ready_pulses got %0d want 1", tx_cnt); end
  endtask

  task automatic test_mode3_lsb16;
    logic [15:0] got, want2; logic bm;
`ifdef SPISLV_ECHO_EN
    want2 = 16'h1234;
`else
    want2 = 16'h0000;
`endif
    set_mode(1, 1, 1, 1);
    bus.tx_valid = 1'b0;
    do_reset;
    spi_frame(16'h1234, 0, got, bm);
    checks++; if (bus.rx_data !== 16'h1234) begin errors++; $display("FAIL m3_rx_data got %h want 1234", bus.rx_data); end
    checks++; if (got !== 16'h0000) begin errors++; $display("FAIL m3_miso_idle got %h want 0000", got); end
    bus.rx_ready = 1'b1; tick; bus.rx_ready = 1'b0;
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL m3_rx_consume got %b want 0", bus.rx_valid); end
    spi_frame(16'hABCD, 0, got, bm);
    checks++; if (bus.rx_data !== 16'hABCD) begin errors++; $display("FAIL m3_rx_data2 got %h want abcd", bus.rx_data); end
    checks++; if (got !== want2) begin errors++; $display("FAIL m3_miso2 got %h want %h", got, want2); end
  endtask

  task automatic test_overrun;
    logic [15:0] got; logic bm;
    set_mode(0, 0, 0, 0);
    bus.tx_valid = 1'b0;
    do_reset;
    spi_frame(16'h0011, 0, got, bm);
    spi_frame(16'h0022, 0, got, bm);
    checks++; if (bus.rx_data !== 16'h0011) begin errors++; $display("FAIL ovr_rx_data got %h want 0011", bus.rx_data); end
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", bus.overrun); end
    checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_rx_valid got %b want 1", bus.rx_valid); end
    do_reset;
    spi_frame(16'h0011, 0, got, bm);
    spi_frame(16'h0022, 1, got, bm);
    checks++; if (bus.rx_data !== 16'h0022) begin errors++; $display("FAIL done_rd_rx_data got %h want 0022", bus.rx_data); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL done_rd_overrun got %b want 0", bus.overrun); end
    checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL done_rd_rx_valid got %b want 1", bus.rx_valid); end
  endtask

  task automatic test_modes12;
    logic [15:0] got; logic bm;
    for (int m = 1; m <= 2; m++) begin
      set_mode(m == 2, m == 1, 0, 0);
      bus.tx_data = 16'h0096; bus.tx_valid = 1'b1;
      do_reset; tick; tick; bus.tx_valid = 1'b0;
      spi_frame(16'h00C3, 0, got, bm);
      checks++; if (bus.rx_data !== 16'h00C3) begin errors++; $display("FAIL mode%0d_rx_data got %h want 00c3", m, bus.rx_data); end
      checks++; if (got[7:0] !== 8'h96) begin errors++; $display("FAIL mode%0d_miso got %h want 96", m, got[7:0]); end
      checks++; if (bm !== 1'b1) begin errors++; $display("FAIL mode%0d_busy_mid got %b want 1", m, bm); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mode%0d_busy_end got %b want 0", m, bus.busy); end
    end
  endtask

  task automatic test_timeout;
    logic [15:0] got; logic bm;
    set_mode(0, 0, 0, 0);
    bus.tx_valid = 1'b0;
    do_reset;
    bus.mosi = 1'b1; repeat (H) tick;
    bus.sck = 1'b1; repeat (H) tick;
    bus.sck = 1'b0; repeat (H) tick;
    bus.sck = 1'b1; repeat (H) tick;
    bus.sck = 1'b0; bus.mosi = 1'b0;
    repeat (300) tick;
    checks++; if (fe_cnt !== 1) begin errors++; $display("FAIL to_frame_err_pulses got %0d want 1", fe_cnt); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL to_busy got %b want 0", bus.busy); end
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL to_rx_valid got %b want 0", bus.rx_valid); end
    spi_frame(16'h005A, 0, got, bm);
    checks++; if (bus.rx_data !== 16'h005A) begin errors++; $display("FAIL to_next_rx_data got %h want 005a", bus.rx_data); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] got; logic bm;
    set_mode(0, 0, 0, 0);
    bus.tx_data = 16'h00FF; bus.tx_valid = 1'b1;
    do_reset;
    spi_frame(16'h0081, 0, got, bm);
    for (int i = 0; i < 4; i++) begin
      bus.mosi = 1'b1; repeat (H) tick;
      bus.sck = 1'b1; repeat (H) tick;
      if (i < 3) bus.sck = 1'b0;
    end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rm_busy_before got %b want 1", bus.busy); end
    bus.sck = 1'b0; bus.mosi = 1'b0; prst = 1'b1; tick;
    checks++; if (bus.miso !== 1'b0) begin errors++; $display("FAIL rm_miso got %b want 0", bus.miso); end
    checks++; if (bus.rx_data !== 16'h0) begin errors++; $display("FAIL rm_rx_data got %h want 0000", bus.rx_data); end
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL rm_rx_valid got %b want 0", bus.rx_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b want 0", bus.busy); end
    checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL rm_tx_ready got %b want 0", bus.tx_ready); end
    bus.tx_valid = 1'b0; prst = 1'b0; tick;
    spi_frame(16'h00F0, 0, got, bm);
    checks++; if (bus.rx_data !== 16'h00F0) begin errors++; $display("FAIL rm_next_rx_data got %h want 00f0", bus.rx_data); end
    checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL rm_next_rx_valid got %b want 1", bus.rx_valid); end
  endtask

  initial begin
    test_reset;
    test_mode0;
    test_mode3_lsb16;
    test_overrun;
    test_modes12;
    test_timeout;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
